// File: rtl/vx_dispatch_sink.sv
// Dispatch sink for one execution unit: a FIFO of matching dispatches, a misroute
// detector, and per-warp pending-writeback counters.
module vx_dispatch_sink #(
  parameter int EX_ID       = 0,
  parameter int DEPTH       = 4,
  parameter int PEND_BITS   = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 16,
  parameter int XLEN        = 32,
  parameter int EX_BITS     = 3,
  parameter int OP_BITS     = 4,
  parameter int MOD_BITS    = 3,
  parameter int NR_BITS     = 5,
  localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NT_BITS    = $clog2(NUM_THREADS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dispatch_valid,
  input  logic [UUID_BITS-1:0]   dispatch_uuid,
  input  logic [NW_BITS-1:0]     dispatch_wid,
  input  logic [NUM_THREADS-1:0] dispatch_tmask,
  input  logic [XLEN-1:0]        dispatch_PC,
  input  logic [EX_BITS-1:0]     dispatch_ex_type,
  input  logic [OP_BITS-1:0]     dispatch_op_type,
  input  logic [MOD_BITS-1:0]    dispatch_op_mod,
  input  logic                   dispatch_wb,
  input  logic                   dispatch_use_PC,
  input  logic                   dispatch_use_imm,
  input  logic [XLEN-1:0]        dispatch_imm,
  input  logic [NR_BITS-1:0]     dispatch_rd,
  output logic                   dispatch_ready,
  output logic                   exec_valid,
  input  logic                   exec_ready,
  output logic [UUID_BITS-1:0]   exec_uuid,
  output logic [NW_BITS-1:0]     exec_wid,
  output logic [NUM_THREADS-1:0] exec_tmask,
  output logic [XLEN-1:0]        exec_PC,
  output logic [OP_BITS-1:0]     exec_op_type,
  output logic [MOD_BITS-1:0]    exec_op_mod,
  output logic                   exec_wb,
  output logic                   exec_use_PC,
  output logic                   exec_use_imm,
  output logic [XLEN-1:0]        exec_imm,
  output logic [NR_BITS-1:0]     exec_rd,
  output logic [NT_BITS-1:0]     exec_nthreads,
  input  logic                   commit_valid,
  input  logic [NW_BITS-1:0]     commit_wid,
  output logic [NUM_WARPS-1:0]   pending_mask,
  output logic                   err_misroute,
  output logic                   err_underflow,
  output logic [7:0]             misroute_cnt
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int ENTRY_W  = UUID_BITS + NW_BITS + NUM_THREADS + XLEN + OP_BITS + MOD_BITS
                          + 3 + XLEN + NR_BITS + NT_BITS;

  function automatic logic [NT_BITS-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [NT_BITS-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + NT_BITS'(mask[i]);
    end
    return cnt;
  endfunction

  logic [ENTRY_W-1:0]   mem_r [DEPTH];
  logic [ENTRY_W-1:0]   push_entry_s;
  logic [PTR_BITS-1:0]  head_r, tail_r;
  logic [CNT_BITS-1:0]  count_r;
  logic                 match_s, ready_s, push_s, pop_s, misroute_s, nonempty_s;
  logic [PEND_BITS-1:0] pend_r    [NUM_WARPS];
  logic [PEND_BITS-1:0] pend_nxt_s[NUM_WARPS];
  logic [NUM_WARPS-1:0] inc_s, dec_s, pending_mask_r;
  logic                 underflow_s;
  logic                 err_misroute_r, err_underflow_r;
  logic [7:0]           misroute_cnt_r;

  assign match_s    = (dispatch_ex_type == EX_BITS'(EX_ID));
  assign nonempty_s = (count_r != CNT_BITS'(0));

  // Acceptance: misrouted traffic is always drained, matching traffic only when not full.
  always_comb begin
    ready_s = 1'b0;
    if (reset) begin
      ready_s = 1'b0;
    end else if (!match_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (count_r < CNT_BITS'(DEPTH));
    end
  end

  assign push_s     = dispatch_valid && ready_s && match_s;
  assign misroute_s = dispatch_valid && ready_s && !match_s;
  assign pop_s      = nonempty_s && exec_ready;

  // Thread count is computed once at enqueue so the head entry drives it straight from storage.
  assign push_entry_s = {dispatch_uuid, dispatch_wid, dispatch_tmask, dispatch_PC,
                         dispatch_op_type, dispatch_op_mod, dispatch_wb, dispatch_use_PC,
                         dispatch_use_imm, dispatch_imm, dispatch_rd, popcount(dispatch_tmask)};

  assign {exec_uuid, exec_wid, exec_tmask, exec_PC, exec_op_type, exec_op_mod, exec_wb,
          exec_use_PC, exec_use_imm, exec_imm, exec_rd, exec_nthreads} = mem_r[head_r];

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= push_entry_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_BITS'(1);
      if (pop_s)  head_r <= head_r + PTR_BITS'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_BITS'(1);
        2'b01:   count_r <= count_r - CNT_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Misroute detection and saturating count.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_misroute_r <= 1'b0;
      misroute_cnt_r <= 8'd0;
    end else if (misroute_s) begin
      err_misroute_r <= 1'b1;
      if (misroute_cnt_r != 8'hFF) misroute_cnt_r <= misroute_cnt_r + 8'd1;
    end
  end

  // Per-warp increment/decrement requests.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc_s[w] = push_s && dispatch_wb && (dispatch_wid == NW_BITS'(w));
      dec_s[w] = commit_valid && (commit_wid == NW_BITS'(w));
    end
  end

  // Next pending counts: saturate at max, hold at zero and flag underflow.
  always_comb begin
    underflow_s = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pend_nxt_s[w] = pend_r[w];
      case ({inc_s[w], dec_s[w]})
        2'b10: begin
          if (pend_r[w] != {PEND_BITS{1'b1}}) pend_nxt_s[w] = pend_r[w] + PEND_BITS'(1);
          else                                pend_nxt_s[w] = pend_r[w];
        end
        2'b01: begin
          if (pend_r[w] != PEND_BITS'(0)) pend_nxt_s[w] = pend_r[w] - PEND_BITS'(1);
          else                            underflow_s   = 1'b1;
        end
        default: pend_nxt_s[w] = pend_r[w];
      endcase
    end
  end

  // Pending counters, their nonzero mask and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) pend_r[w] <= '0;
      pending_mask_r  <= '0;
      err_underflow_r <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pend_r[w]         <= pend_nxt_s[w];
        pending_mask_r[w] <= (pend_nxt_s[w] != PEND_BITS'(0));
      end
      if (underflow_s) err_underflow_r <= 1'b1;
    end
  end

  assign dispatch_ready = ready_s;
  assign exec_valid     = nonempty_s && !reset;
  assign pending_mask   = reset ? '0 : pending_mask_r;
  assign err_misroute   = err_misroute_r;
  assign err_underflow  = err_underflow_r;
  assign misroute_cnt   = misroute_cnt_r;

endmodule
